// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 4-digit seven-segment scan driver:
//   NUM_DIGITS  - number of multiplexed digits on the display
//   digit_idx_t - index type of the currently selected digit
//   AN_ALL_OFF  - anode pattern with every digit dark (anodes are active-low)
//   an_onecold  - active-low anode pattern that lights exactly one digit
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    localparam logic [3:0] AN_ALL_OFF = 4'b1111;

    function automatic logic [3:0] an_onecold(input digit_idx_t d);
        return ~(4'b0001 << d);
    endfunction

endpackage : seg_pkg

// File: rtl/seg_refresh_tick.sv
// -----------------------------------------------------------------------------
// seg_refresh_tick
// Free-running prescaler that counts 0..REFRESH_DIV-1 and wraps. tick is high
// during the last count of each period, so one tick occurs every REFRESH_DIV
// cycles. With REFRESH_DIV=1 the counter is pinned at 0 and tick is always 1.
//
// Parameters:
//   REFRESH_DIV - period in clock cycles (>= 1)
// Ports:
//   clk   in  1 - system clock
//   rst_n in  1 - synchronous active-low reset (counter returns to 0)
//   tick  out 1 - high in the final cycle of each period
// -----------------------------------------------------------------------------
module seg_refresh_tick #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    // A single-cycle period still needs a 1-bit counter to stay legal.
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule : seg_refresh_tick

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexes a 16-bit value (four hex nibbles) onto one shared hex7seg
// decoder and the four active-low anodes of a 4-digit display. The incoming
// value is double-buffered: loads are staged and only committed to the display
// register at a frame boundary (tick while digit 3 is selected), so a single
// scan frame never mixes old and new digits.
//
// Optional build macro:
//   SEG_SCAN_LZB_EN - leading-zero blanking; digit i (3..1) is dark when the
//                     displayed nibbles i..3 are all zero. Digit 0 always lit
//                     unless blanked by the blank input.
//
// Parameters:
//   REFRESH_DIV - clock cycles each digit stays lit (>= 1)
// Ports:
//   clk       in  1  - system clock
//   rst_n     in  1  - synchronous active-low reset
//   value     in  16 - digit3=[15:12] .. digit0=[3:0]
//   load      in  1  - capture value for display (level, sampled every cycle)
//   blank     in  4  - per-digit force-off, bit i = digit i
//   nibble    out 4  - nibble of the selected digit, to hex7seg
//   an        out 4  - active-low anodes, one-cold or all-ones
//   digit_sel out 2  - index of the selected digit
//   load_ack  out 1  - one-cycle pulse in the first cycle showing a new value
// -----------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  blank,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic [1:0]  digit_sel,
    output logic        load_ack
);

    localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

    logic        tick;
    logic        commit;
    digit_idx_t  sel;
    logic [15:0] disp;
    logic [15:0] stage;
    logic        pending;
    logic        ack;
    logic [3:0]  lzb_mask;
    logic [3:0]  blank_eff;

    seg_refresh_tick #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // The frame ends on the tick that moves the scan from digit 3 back to 0.
    assign commit = tick && (sel == LAST_DIGIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel     <= '0;
            disp    <= '0;
            stage   <= '0;
            pending <= 1'b0;
            ack     <= 1'b0;
        end else begin
            if (tick) begin
                sel <= sel + 2'd1;
            end
            ack <= 1'b0;
            if (commit) begin
                // A load arriving in the commit cycle bypasses the stage so it
                // reaches the display with single-cycle latency.
                if (load) begin
                    disp <= value;
                end else if (pending) begin
                    disp <= stage;
                end
                pending <= 1'b0;
                ack     <= load | pending;
            end else if (load) begin
                stage   <= value;
                pending <= 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    always_comb begin
        lzb_mask    = 4'b0000;
        lzb_mask[3] = (disp[15:12] == 4'h0);
        lzb_mask[2] = (disp[15:8]  == 8'h00);
        lzb_mask[1] = (disp[15:4]  == 12'h000);
    end
`else
    assign lzb_mask = 4'b0000;
`endif

    assign blank_eff = blank | lzb_mask;

    // The nibble is driven even for a dark digit so the decoder input only
    // depends on the scan position.
    always_comb begin
        nibble = disp[3:0];
        unique case (sel)
            2'd0: nibble = disp[3:0];
            2'd1: nibble = disp[7:4];
            2'd2: nibble = disp[11:8];
            2'd3: nibble = disp[15:12];
            default: nibble = disp[3:0];
        endcase
    end

    assign an        = blank_eff[sel] ? AN_ALL_OFF : an_onecold(sel);
    assign digit_sel = sel;
    assign load_ack  = ack;

endmodule : seg_scan_driver

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Self-checking bench for seg_scan_driver with REFRESH_DIV=4. A behavioural
// model tracks the cycle index since reset, the value on display and the last
// staged load, and derives every output from the scan arithmetic. Directed
// scenarios add literal expectations, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  blank = 4'b0000;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic [1:0]  digit_sel;
    logic        load_ack;

    seg_scan_driver #(
        .REFRESH_DIV(DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .load     (load),
        .blank    (blank),
        .nibble   (nibble),
        .an       (an),
        .digit_sel(digit_sel),
        .load_ack (load_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state describing the current clock cycle.
    int          m_t     = 0;
    logic [15:0] m_shown = 16'h0000;
    logic [15:0] m_stage = 16'h0000;
    bit          m_pend  = 1'b0;
    bit          m_ack   = 1'b0;
    bit          m_valid = 1'b0;
    int          ack_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_an(input int d, input logic [15:0] shown,
                                          input logic [3:0] blk);
        bit off;
        off = blk[d];
`ifdef SEG_SCAN_LZB_EN
        if (d > 0 && (shown >> (4 * d)) == 16'h0000) off = 1'b1;
`endif
        return off ? 4'hF : (4'hF ^ (4'd1 << d));
    endfunction

    // Compare the DUT against the model, then advance the model using the
    // inputs that the next rising edge will sample.
    always @(negedge clk) begin
        int d;
        if (m_valid) begin
            d = (m_t / DIV) % 4;
            check("digit_sel", 32'(digit_sel), 32'(d));
            check("nibble", 32'(nibble), 32'((m_shown >> (4 * d)) & 16'h000F));
            check("an", 32'(an), 32'(exp_an(d, m_shown, blank)));
            check("load_ack", 32'(load_ack), 32'(m_ack));
            if (load_ack === 1'b1) ack_seen++;
        end
        if (!rst_n) begin
            m_t = 0; m_shown = '0; m_stage = '0; m_pend = 0; m_ack = 0; m_valid = 1;
        end else if (m_valid) begin
            m_ack = 0;
            if (m_t % FRAME == FRAME - 1) begin
                if (load) begin
                    m_shown = value; m_ack = 1;
                end else if (m_pend) begin
                    m_shown = m_stage; m_ack = 1;
                end
                m_pend = 0;
            end else if (load) begin
                m_stage = value; m_pend = 1;
            end
            m_t++;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_phase(input int ph);
        int k;
        k = 0;
        while ((m_t % FRAME) != ph && k < 100) begin
            step();
            k++;
        end
        check("wait_phase_timeout", 32'(k < 100), 32'd1);
    endtask

    task automatic load_at_commit(input logic [15:0] v);
        wait_phase(FRAME - 1);
        load = 1'b1; value = v;
        step();
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] an_seq [4];
        logic [3:0] lit;
        int         acks0;
        int         hits;
        an_seq[0] = 4'b1110; an_seq[1] = 4'b1101; an_seq[2] = 4'b1011; an_seq[3] = 4'b0111;

        // Reset held for two edges.
        step();
        check("rst_an", 32'(an), 32'h0000000E);
        check("rst_nibble", 32'(nibble), 32'h0);
        check("rst_ack", 32'(load_ack), 32'h0);
        step();
        rst_n = 1'b1;

        // Anode scan sequence after release.
        for (int i = 0; i < 2 * FRAME; i++) begin
            check("an_seq", 32'(an), 32'(an_seq[(i / DIV) % 4]));
            step();
        end

        // Load mid-frame while digit 1 is selected.
        wait_phase(DIV + 1);
        load = 1'b1; value = 16'h1A3F;
        step();
        load = 1'b0;
        check("mid_hold", 32'(nibble), 32'h0);
        wait_phase(0);
        check("mid_ack", 32'(load_ack), 32'h1);
        check("mid_d0", 32'(nibble), 32'hF);
        step();
        check("mid_ack_pulse", 32'(load_ack), 32'h0);
        wait_phase(DIV);     check("mid_d1", 32'(nibble), 32'h3);
        wait_phase(2 * DIV); check("mid_d2", 32'(nibble), 32'hA);
        wait_phase(3 * DIV); check("mid_d3", 32'(nibble), 32'h1);

        // Two loads in one frame: the later one wins, one ack.
        wait_phase(2);
        load = 1'b1; value = 16'h1111;
        step();
        load = 1'b0;
        step(3);
        load = 1'b1; value = 16'h2222;
        step();
        load = 1'b0;
        acks0 = ack_seen;
        wait_phase(0);
        check("lw_d0", 32'(nibble), 32'h2);
        wait_phase(DIV);
        check("lw_ack_count", 32'(ack_seen - acks0), 32'd1);
        check("lw_d1", 32'(nibble), 32'h2);

        // Load in the commit cycle shows up immediately.
        load_at_commit(16'h00C5);
        check("cc_sel", 32'(digit_sel), 32'h0);
        check("cc_d0", 32'(nibble), 32'h5);
        check("cc_ack", 32'(load_ack), 32'h1);

        // Per-digit blank on digit 2.
        load_at_commit(16'h4700);
        blank = 4'b0100;
        hits = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (an == 4'b1011) hits++;
            if (digit_sel == 2'd2) check("blank_nibble", 32'(nibble), 32'h7);
            step();
        end
        check("blank_never_1011", 32'(hits), 32'd0);
        blank = 4'b0000;

        // Leading-zero behaviour.
        load_at_commit(16'h0050);
        lit = 4'b0000;
        for (int i = 0; i < FRAME; i++) begin
            lit = lit | ~an;
            step();
        end
`ifdef SEG_SCAN_LZB_EN
        check("lzb_0050", 32'(lit), 32'h3);
`else
        check("lzb_0050", 32'(lit), 32'hF);
`endif
        load_at_commit(16'h0000);
        lit = 4'b0000;
        for (int i = 0; i < FRAME; i++) begin
            lit = lit | ~an;
            step();
        end
`ifdef SEG_SCAN_LZB_EN
        check("lzb_0000", 32'(lit), 32'h1);
`else
        check("lzb_0000", 32'(lit), 32'hF);
`endif

        // Reset mid-frame with a load pending.
        load_at_commit(16'h3333);
        wait_phase(2 * DIV);
        load = 1'b1; value = 16'h9999;
        step();
        load = 1'b0;
        rst_n = 1'b0;
        step();
        check("mr_an", 32'(an), 32'h0000000E);
        check("mr_nibble", 32'(nibble), 32'h0);
        rst_n = 1'b1;
        acks0 = ack_seen;
        step(3 * FRAME);
        check("mr_no_ack", 32'(ack_seen - acks0), 32'd0);
        check("mr_disp_zero", 32'(nibble), 32'h0);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 1200; i++) begin
            load  = ($urandom_range(0, 5) == 0);
            value = 16'($urandom);
            blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            rst_n = ($urandom_range(0, 249) != 0);
            step();
        end
        load = 1'b0; blank = 4'b0000; rst_n = 1'b1;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seg_scan_driver

// File: doc/seg_scan_driver.md
# seg_scan_driver

- Time-multiplexes a 16-bit value (four hex nibbles) onto one shared `hex7seg` decoder and the four active-low anodes of the board's 4-digit display.
- Sits directly upstream of `hex7seg`: `nibble` drives its `n` input; `an` goes to the display anodes.
- Double-buffers the incoming value. Updates commit only at a scan-frame boundary, so a frame never shows a mix of old and new digits.

## Interface
- `REFRESH_DIV`, 100000 — clock cycles each digit is lit. Legal range ≥1; counter width is `$clog2(REFRESH_DIV)`, minimum 1.
- `clk`  in  1  — system clock.
- `rst_n`  in  1  — synchronous, active-low reset.
- `value`  in  16  — digit3 = [15:12] … digit0 = [3:0].
- `load`  in  1  — capture `value` for display (level sampled each cycle).
- `blank`  in  4  — per-digit force-off; bit i = digit i.
- `nibble`  out  4  — nibble of the currently selected digit, to `hex7seg`.
- `an`  out  4  — anode enables, active-low, one-cold or all-ones.
- `digit_sel`  out  2  — index of the selected digit.
- `load_ack`  out  1  — one-cycle pulse: captured value is now displayed.

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and wraps. `tick` = (count == REFRESH_DIV-1).
- On `tick`, `digit_sel` advances 0→1→2→3→0.
- Commit cycle = the cycle with `tick` and `digit_sel`==3.
- Staging:
  - `load`=1 in a non-commit cycle: stage <= `value` and `pending` <= 1.
  - Repeated loads before commit: the last one wins.
- Commit:
  - If `load`=1 in the commit cycle: disp <= `value`.
  - Else if `pending`: disp <= stage.
  - In either case `pending` <= 0 and `load_ack`=1 in the following cycle only.
  - Neither set: disp holds and no ack.
- Outputs are combinational decodes of registers only (`digit_sel`, disp, `blank`):
  - `nibble` = disp[4*digit_sel +: 4].
  - `an` = ~(1 << digit_sel), forced to 4'b1111 if the selected digit is blanked.
- `nibble` is driven even when the digit is blanked.
- Reset values, taken at the first `clk` edge with `rst_n`=0:
  - prescaler 0, `digit_sel` 0, disp 0, stage 0, `pending` 0, `load_ack` 0.
  - Hence `an`=4'b1110 and `nibble`=0.
- Reset mid-frame discards any pending load; no ack is produced for it.

## Timing
- Each digit is lit for exactly REFRESH_DIV cycles; one frame = 4·REFRESH_DIV cycles.
- After reset release, the first `digit_sel` change occurs at the edge ending cycle REFRESH_DIV-1.
- Load-to-display latency: from 1 cycle (load in commit cycle) up to 4·REFRESH_DIV cycles.
- Disp, `digit_sel` (3→0) and `an` change on the same edge, so digit 0 of the new frame shows the new value.
- `load_ack` is high during that first cycle of the new frame.
- REFRESH_DIV=1: `tick` is always 1, digits advance every cycle, and every fourth cycle is a commit cycle.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking.
  - Digit i (i=3..1) is blanked when disp nibbles i..3 are all zero.
  - Digit 0 is never blanked by this rule.
  - Effective blank = `blank` | lzb_mask.
- Undefined: only `blank` affects `an`; zeros are displayed.

## Structure
- Package `seg_pkg` holds:
  - `NUM_DIGITS`=4.
  - Typedef `digit_idx_t` (2-bit).
  - Constant `AN_ALL_OFF`=4'b1111.
- Sub-module `seg_refresh_tick`: parameterized prescaler.
  - Ports `clk`, `rst_n`, `tick`.
  - Same reset rules as this block.
- `hex7seg` is instantiated by the parent, not inside this block.

## Test plan
Run with REFRESH_DIV=4.
- Reset: hold `rst_n`=0 for 2 cycles, then release.
  - During reset: `an`=1110, `nibble`=0, `load_ack`=0.
  - After release: `an` sequence 1110,1101,1011,0111, each 4 cycles, repeating.
- Load mid-frame: pulse `load` with `value`=16'h1A3F while `digit_sel`=1.
  - Display stays 0 until commit; `load_ack` is 1 for one cycle.
  - Then digits 0..3 show F,3,A,1.
- Last load wins: loads 16'h1111 then 16'h2222 in the same frame.
  - Exactly one `load_ack`; display shows 2222.
- Load in commit cycle: `load` with 16'h00C5 in the commit cycle.
  - Digit 0 shows 5 in the next cycle, with `load_ack`=1 that cycle.
- Blanking:
  - `blank`=4'b0100: `an` never equals 1011; `nibble` still shows digit 2's value in its slot.
  - With `SEG_SCAN_LZB_EN`: 16'h0050 lights only digits 1 and 0; 16'h0000 lights only digit 0.
  - Without the macro: all four digits lit in both cases.
- Reset mid-operation: assert `rst_n`=0 at `digit_sel`=2 with a load pending.
  - Display returns to 0, `an`=1110, and no `load_ack` ever follows.
